// File: rtl/acc_pkg.sv
// Shared types and default widths for the sequential multi-operand accumulator.
package acc_pkg;

  localparam int ACC_DATA_WIDTH = 4;
  localparam int ACC_CNT_WIDTH  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } acc_state_t;

endpackage

// File: rtl/seq_accumulator_rca_n.sv
// N-bit combinational ripple-carry adder (a + b + cin -> sum, cout).
module rca_n #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[N];

endmodule

// File: rtl/seq_accumulator.sv
// Burst accumulator: sums LEN operands through one rca_n, reports sum + sticky carry.
// Optional macro ACC_SATURATE_EN clamps the accumulator to all-ones on any carry-out.
module seq_accumulator
  import acc_pkg::*;
#(
  parameter int DATA_WIDTH = ACC_DATA_WIDTH,
  parameter int CNT_WIDTH  = ACC_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_sum,
  output logic                  out_carry,
  output logic                  busy
);

  acc_state_t            r_state;
  acc_state_t            w_state_nxt;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  r_len_q;
  logic                  r_carry_q;

  logic [DATA_WIDTH-1:0] w_sum;
  logic                  w_cout;
  logic [DATA_WIDTH-1:0] w_acc_nxt;
  logic                  w_accept;
  logic                  w_last;

  rca_n #(.N(DATA_WIDTH)) u_rca (
    .a    (r_acc),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );

`ifdef ACC_SATURATE_EN
  // Once saturated, acc is all-ones so any further non-zero add carries out again.
  assign w_acc_nxt = w_cout ? {DATA_WIDTH{1'b1}} : w_sum;
`else
  assign w_acc_nxt = w_sum;
`endif

  assign w_accept = (r_state == ST_ACCUM) && in_valid;
  assign w_last   = (r_cnt == (r_len_q - CNT_WIDTH'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = (len == '0) ? ST_DONE : ST_ACCUM;
      ST_ACCUM: if (w_accept && w_last) w_state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_len_q   <= '0;
      r_carry_q <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_len_q   <= len;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_carry_q <= 1'b0;
          end
        end
        ST_ACCUM: begin
          if (w_accept) begin
            r_acc     <= w_acc_nxt;
            r_carry_q <= r_carry_q | w_cout;
            // Hold at len_q-1 on the final operand; the next burst clears it.
            if (!w_last) r_cnt <= r_cnt + CNT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // The result is only exposed in DONE so a partial sum never leaks out.
  assign in_ready  = (r_state == ST_ACCUM);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign out_sum   = (r_state == ST_DONE) ? r_acc : '0;
  assign out_carry = (r_state == ST_DONE) && r_carry_q;

endmodule
